// File: rtl/e203_int_recv.sv
// Receiving end of the E203 interrupt pulse line: synchronizes an async pulse,
// measures its high time in microseconds, filters glitches and holds it pending until ack.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a rising edge on the synchronized input
// MEASURE | input high; counting cycles/us until the falling edge
module e203_int_recv #(
    parameter int unsigned CLK_FREQ     = 125,
    parameter int unsigned MIN_WIDTH_US = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       int_in,
    input  logic       int_ack,
    output logic       int_pending,
    output logic       int_valid,
    output logic [9:0] int_width_us,
    output logic       int_overrun,
    output logic [7:0] int_count
);

    localparam int unsigned    CW       = $clog2(CLK_FREQ);
    localparam logic [CW-1:0]  CLK_LAST = CW'(CLK_FREQ - 1);
    localparam logic [9:0]     US_MAX   = 10'd1023;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic          s1;
    logic          int_s;
    logic          int_s_d;
    logic          rise;
    logic [CW-1:0] cnt_clk;
    logic [9:0]    cnt_us;
    logic          width_ok;
    logic          start;
    logic          count_en;
    logic          accept;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1      <= 1'b0;
            int_s   <= 1'b0;
            int_s_d <= 1'b0;
        end else begin
            s1      <= int_in;
            int_s   <= s1;
            int_s_d <= int_s;
        end
    end

    assign rise     = int_s & ~int_s_d;
    assign width_ok = 32'(cnt_us) >= MIN_WIDTH_US;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rise)   state_next = MEASURE;
            MEASURE: if (!int_s) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    always_comb begin
        start    = 1'b0;
        count_en = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                start = rise;
            end
            MEASURE: begin
                if (int_s) begin
                    count_en = 1'b1;
                end else begin
                    accept = width_ok;
                end
            end
            default: begin
                start = 1'b0;
            end
        endcase
    end

    // The rising-edge cycle already counts as the first high cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_clk <= '0;
            cnt_us  <= '0;
        end else if (start) begin
            cnt_clk <= CW'(1);
            cnt_us  <= '0;
        end else if (count_en) begin
            if (cnt_clk == CLK_LAST) begin
                cnt_clk <= '0;
                if (cnt_us != US_MAX) begin
                    cnt_us <= cnt_us + 10'd1;
                end
            end else begin
                cnt_clk <= cnt_clk + 1'b1;
            end
        end else begin
            cnt_clk <= '0;
            cnt_us  <= '0;
        end
    end

    // An accept wins over a simultaneous ack; the ack then only clears overrun.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            int_pending  <= 1'b0;
            int_valid    <= 1'b0;
            int_width_us <= '0;
            int_overrun  <= 1'b0;
            int_count    <= '0;
        end else begin
            int_valid <= accept;
            if (accept) begin
                int_pending  <= 1'b1;
                int_width_us <= cnt_us;
                int_count    <= int_count + 8'd1;
                int_overrun  <= ~int_ack & (int_pending | int_overrun);
            end else if (int_ack) begin
                int_pending <= 1'b0;
                int_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_e203_int_recv.sv
// Bench for e203_int_recv: three instances (125/1, 125/0, 2/1) share stimulus and are
// checked every cycle against a pulse-length model, plus literal spot checks.
module tb_e203_int_recv;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       int_in  = 1'b0;
    logic       int_ack = 1'b0;
    logic       pend  [3];
    logic       valid [3];
    logic       ovr   [3];
    logic [9:0] width [3];
    logic [7:0] cnt   [3];

    e203_int_recv #(.CLK_FREQ(125), .MIN_WIDTH_US(1)) u_a (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .int_in(int_in), .int_ack(int_ack),
        .int_pending(pend[0]), .int_valid(valid[0]), .int_width_us(width[0]),
        .int_overrun(ovr[0]), .int_count(cnt[0]));

    e203_int_recv #(.CLK_FREQ(125), .MIN_WIDTH_US(0)) u_b (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .int_in(int_in), .int_ack(int_ack),
        .int_pending(pend[1]), .int_valid(valid[1]), .int_width_us(width[1]),
        .int_overrun(ovr[1]), .int_count(cnt[1]));

    e203_int_recv #(.CLK_FREQ(2), .MIN_WIDTH_US(1)) u_c (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .int_in(int_in), .int_ack(int_ack),
        .int_pending(pend[2]), .int_valid(valid[2]), .int_width_us(width[2]),
        .int_overrun(ovr[2]), .int_count(cnt[2]));

    always #5 sys_clk = ~sys_clk;

    int tests = 0;
    int fails = 0;
    int vcnt_a = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            if (fails <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: track the synchronized input (2-cycle delay), the length of the current
    // high run, and derive the outputs from run length at each falling edge.
    int   m_freq [3] = '{125, 125, 2};
    int   m_min  [3] = '{1, 0, 1};
    logic m_s1 = 1'b0;
    logic m_s  = 1'b0;
    bit   m_live = 1'b0;
    int   run     [3];
    int   e_pend  [3];
    int   e_valid [3];
    int   e_width [3];
    int   e_ovr   [3];
    int   e_cnt   [3];

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_s1   = 1'b0;
            m_s    = 1'b0;
            m_live = 1'b1;
            for (int i = 0; i < 3; i++) begin
                run[i] = 0; e_pend[i] = 0; e_valid[i] = 0;
                e_width[i] = 0; e_ovr[i] = 0; e_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int  w;
                bit  acc;
                w   = 0;
                acc = 1'b0;
                if (m_s) begin
                    run[i]++;
                end else if (run[i] > 0) begin
                    w = run[i] / m_freq[i];
                    if (w > 1023) w = 1023;
                    acc    = (w >= m_min[i]);
                    run[i] = 0;
                end
                e_valid[i] = int'(acc);
                if (acc) begin
                    e_ovr[i]   = (int_ack) ? 0 : ((e_pend[i] != 0) ? 1 : e_ovr[i]);
                    e_pend[i]  = 1;
                    e_width[i] = w;
                    e_cnt[i]   = (e_cnt[i] + 1) % 256;
                end else if (int_ack) begin
                    e_pend[i] = 0;
                    e_ovr[i]  = 0;
                end
            end
            m_s  = m_s1;
            m_s1 = int_in;
        end
    end

    always @(negedge sys_clk) begin
        if (m_live) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d pending", i), int'(pend[i]),  e_pend[i]);
                chk($sformatf("u%0d valid", i),   int'(valid[i]), e_valid[i]);
                chk($sformatf("u%0d width", i),   int'(width[i]), e_width[i]);
                chk($sformatf("u%0d overrun", i), int'(ovr[i]),   e_ovr[i]);
                chk($sformatf("u%0d count", i),   int'(cnt[i]),   e_cnt[i]);
            end
        end
    end

    // Every stimulus step ends just after a falling clock edge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            vcnt_a += int'(valid[0]);
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        int_in = 1'b1;
        step(hi);
        int_in = 1'b0;
        step(lo);
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        step(2);
        sys_rst = 1'b0;
        step(2);
        vcnt_a = 0;
    endtask

    task automatic ack_once();
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
    endtask

    initial begin
        // reset and idle
        step(3);
        sys_rst = 1'b0;
        step(10);
        chk("idle pending", int'(pend[0]), 0);
        chk("idle valid",   int'(valid[0]), 0);
        chk("idle width",   int'(width[0]), 0);
        chk("idle overrun", int'(ovr[0]), 0);
        chk("idle count",   int'(cnt[0]), 0);

        // reset in the middle of a 200-cycle pulse discards it
        vcnt_a = 0;
        int_in = 1'b1;
        step(60);
        sys_rst = 1'b1;
        step(140);
        int_in = 1'b0;
        step(5);
        sys_rst = 1'b0;
        step(5);
        chk("midrst count a", int'(cnt[0]), 0);
        chk("midrst count b", int'(cnt[1]), 0);
        chk("midrst pend b",  int'(pend[1]), 0);
        chk("midrst valid a", vcnt_a, 0);

        // 252 high cycles -> 2 us
        do_reset();
        pulse(252, 6);
        chk("p252 valid pulses", vcnt_a, 1);
        chk("p252 pending", int'(pend[0]), 1);
        chk("p252 width",   int'(width[0]), 2);
        chk("p252 count",   int'(cnt[0]), 1);
        chk("p252 overrun", int'(ovr[0]), 0);
        chk("p252 model width", e_width[0], 2);

        // 100 high cycles: rejected with MIN=1, accepted as 0 us with MIN=0
        do_reset();
        pulse(100, 6);
        chk("p100 valid pulses a", vcnt_a, 0);
        chk("p100 pending a", int'(pend[0]), 0);
        chk("p100 count a",   int'(cnt[0]), 0);
        chk("p100 pending b", int'(pend[1]), 1);
        chk("p100 width b",   int'(width[1]), 0);
        chk("p100 count b",   int'(cnt[1]), 1);

        // two accepts without ack -> overrun, then ack clears
        do_reset();
        pulse(130, 10);
        pulse(380, 6);
        chk("ovr width",   int'(width[0]), 3);
        chk("ovr count",   int'(cnt[0]), 2);
        chk("ovr overrun", int'(ovr[0]), 1);
        ack_once();
        chk("ack pending", int'(pend[0]), 0);
        chk("ack overrun", int'(ovr[0]), 0);
        step(3);

        // ack coinciding with the accept cycle
        do_reset();
        pulse(130, 6);
        pulse(130, 6);
        chk("coin pre overrun", int'(ovr[0]), 1);
        chk("coin pre width",   int'(width[0]), 1);
        int_in = 1'b1;
        step(260);
        int_in = 1'b0;
        step(2);
        int_ack = 1'b1;
        step(1);
        int_ack = 1'b0;
        chk("coin valid",   int'(valid[0]), 1);
        chk("coin pending", int'(pend[0]), 1);
        chk("coin overrun", int'(ovr[0]), 0);
        chk("coin width",   int'(width[0]), 2);
        chk("coin count",   int'(cnt[0]), 3);
        step(3);
        ack_once();
        chk("coin post ack pending", int'(pend[0]), 0);

        // saturation on the CLK_FREQ=2 instance
        do_reset();
        pulse(2100, 6);
        chk("sat width c", int'(width[2]), 1023);
        chk("sat width a", int'(width[0]), 16);
        chk("sat model width c", e_width[2], 1023);

        // 256 back-to-back pulses with 1-cycle gaps -> count wraps
        do_reset();
        for (int k = 0; k < 255; k++) pulse(4, 1);
        step(5);
        chk("wrap 255 count c", int'(cnt[2]), 255);
        pulse(4, 6);
        chk("wrap count c",   int'(cnt[2]), 0);
        chk("wrap count b",   int'(cnt[1]), 0);
        chk("wrap count a",   int'(cnt[0]), 0);
        chk("wrap pending c", int'(pend[2]), 1);
        chk("wrap width c",   int'(width[2]), 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/e203_int_recv.md
Name: e203_int_recv

Overview:
- Receiving end of the E203 interrupt pulse line.
- Synchronizes an asynchronous interrupt pulse into sys_clk and measures its high time in microsecond units.
- Rejects glitches shorter than a minimum width. Accepted pulses are held as a pending interrupt with their measured width until the core acknowledges them.
- Sits between external/peripheral pulse sources and the E203 interrupt input.

Parameters:
- CLK_FREQ, 125, sys_clk cycles per microsecond (125 MHz => 125); must be >= 2.
- MIN_WIDTH_US, 1, minimum measured width in us for a pulse to be accepted; 0 accepts every pulse.

Ports:
- sys_clk  input  1  system clock, all logic on rising edge
- sys_rst  input  1  synchronous, active-high reset
- int_in  input  1  asynchronous interrupt pulse, active high
- int_ack  input  1  one-cycle acknowledge from core; clears pending/overrun
- int_pending  output  1  accepted interrupt awaiting acknowledge
- int_valid  output  1  one-cycle strobe, asserted the cycle int_pending is set by an accept
- int_width_us  output  10  measured width of last accepted pulse, us, saturating at 1023
- int_overrun  output  1  sticky: a pulse was accepted while int_pending was already set
- int_count  output  8  count of accepted pulses, wraps 255->0

Behaviour:
- Reset (sys_rst=1 at a clock edge):
  - All outputs go to 0: int_pending, int_valid, int_width_us, int_overrun, int_count.
  - Synchronizer flops, edge-history flop and counters clear; FSM goes to IDLE.
  - Reset mid-measurement discards the pulse in flight.
- Synchronizer:
  - Two flops int_in -> s1 -> int_s, giving 2 cycles of latency.
  - A previous-value flop int_s_d provides edge detection.
  - All timing below refers to int_s.
- Counters:
  - cnt_clk: ceil(log2(CLK_FREQ)) bits, range 0..CLK_FREQ-1.
  - cnt_us: 10 bits, saturating.
- FSM state IDLE:
  - On a rising edge (int_s=1, int_s_d=0): go to MEASURE, cnt_clk<=1, cnt_us<=0.
  - Otherwise stay in IDLE with counters at 0.
- FSM state MEASURE, while int_s=1:
  - If cnt_clk==CLK_FREQ-1: cnt_clk<=0 and cnt_us<=cnt_us+1, saturating at 1023.
  - Else: cnt_clk<=cnt_clk+1.
  - Invariant: after k high cycles, cnt_us = min(floor(k/CLK_FREQ), 1023).
- FSM state MEASURE, first cycle with int_s=0 (falling edge), always returning to IDLE:
  - Reject case (cnt_us < MIN_WIDTH_US): no output changes.
  - Accept case (cnt_us >= MIN_WIDTH_US), all registered and visible the next cycle:
    - int_width_us<=cnt_us.
    - int_pending<=1.
    - int_valid<=1 for one cycle.
    - int_count<=int_count+1, modulo 256.
    - int_overrun<=1 if int_pending=1 and int_ack=0 in the accept cycle.
- Acknowledge:
  - int_ack=1 clears int_pending and int_overrun on the next cycle.
  - Ack while int_pending=0 has no effect.
  - Simultaneous accept and ack: the accept wins. int_pending stays 1, int_width_us is updated, int_overrun is not set (it clears to 0).
- A new rising edge cannot occur in the same cycle as a falling edge, so each pulse is measured independently. Back-to-back pulses with a 1-cycle low gap are both measured.
- A pulse held high indefinitely saturates at 1023 and is reported only on its falling edge.
- int_valid is 0 in every cycle other than the cycle after an accept.

Test Plan:
- Reset, then idle 10 cycles -> all outputs 0; assert sys_rst mid-pulse (cycle 60 of 200) -> no accept, int_count stays 0.
- CLK_FREQ=125, MIN=1, int_in high 252 cycles -> int_valid pulses once; int_pending=1, int_width_us=2, int_count=1, int_overrun=0.
- int_in high 100 cycles (MIN=1) -> rejected: int_valid never asserts, int_pending=0, int_count=0; with MIN=0 the same pulse is accepted with int_width_us=0.
- Two accepted pulses (130 then 380 cycles high) with no ack -> int_width_us=3, int_count=2, int_overrun=1; then int_ack -> int_pending=0, int_overrun=0 next cycle.
- Accept timed so int_ack coincides with the accept cycle -> int_pending remains 1, int_overrun=0, int_width_us shows the new width.
- int_in high 130000 cycles -> int_width_us=1023 (saturated); 256 accepted pulses -> int_count wraps to 0.
